// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler and its arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } sched_state_e;

  localparam int UART_FRAME_CYCLES = 11;
  localparam int NUM_REQ_DEFAULT   = 4;

  // One counter serves both the timeout and the inter-frame gap.
  function automatic int cnt_width(input int timeout_cycles, input int gap_cycles);
    int m;
    m = (timeout_cycles > gap_cycles) ? timeout_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter signals of the UART transmit scheduler.
// Handshake: a requester holds i_req_valid[k] and its byte until o_req_ack[k] pulses;
// o_tx_ready is a single-cycle launch and i_tx_done a single-cycle completion pulse.
interface uart_tx_scheduler_if import uart_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_ack;
  logic [NUM_REQ-1:0]   o_req_done;
  logic                 o_err;
  logic [7:0]           o_tx_byte;
  logic                 o_tx_ready;
  logic                 i_tx_done;
  logic                 i_tx_active;
  logic [IDW-1:0]       o_grant_id;
  logic                 o_busy;
  sched_state_e         o_state;

  modport slave (
    input  i_req_valid, i_req_data, i_tx_done, i_tx_active,
    output o_req_ack, o_req_done, o_err, o_tx_byte, o_tx_ready, o_grant_id, o_busy, o_state
  );

  modport master (
    output i_req_valid, i_req_data, i_tx_done, i_tx_active,
    input  o_req_ack, o_req_done, o_err, o_tx_byte, o_tx_ready, o_grant_id, o_busy, o_state
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin requester selection: search starts at i_ptr and wraps NUM_REQ-1 -> 0.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

  logic [IDW:0] cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, i_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!o_any && i_req[cand[IDW-1:0]]) begin
        o_any                   = 1'b1;
        o_idx                   = cand[IDW-1:0];
        o_grant[cand[IDW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters: round-robin grant,
// single launch pulse, completion/timeout tracking and an enforced idle gap.
module uart_tx_scheduler import uart_pkg::*; #(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_scheduler_if.slave  bus
);

  localparam int IDW      = $clog2(NUM_REQ);
  localparam int CW       = cnt_width(TIMEOUT_CYCLES, GAP_CYCLES);
  localparam int TO_LAST  = TIMEOUT_CYCLES - 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  sched_state_e        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [7:0]          byte_q, byte_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDW-1:0]      arb_idx;
  logic                arb_any;
  logic [IDW-1:0]      ptr_next;
  logic [7:0]          sel_byte;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .i_req   (bus.i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (arb_grant),
    .o_idx   (arb_idx),
    .o_any   (arb_any)
  );

  assign ptr_next = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) sel_byte = bus.i_req_data[8*k +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    byte_d  = byte_q;
    gid_d   = gid_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    ready_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any && !bus.i_tx_active) begin
          ack_d   = arb_grant;
          byte_d  = sel_byte;
          gid_d   = arb_idx;
          ptr_d   = ptr_next;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        ready_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the last timeout cycle still counts as success.
        if (bus.i_tx_done) begin
          done_d  = NUM_REQ'(1) << gid_q;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else if (cnt_q == CW'(TO_LAST)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP_LAST)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      byte_q  <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      byte_q  <= byte_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_req_ack  = ack_q;
  assign bus.o_req_done = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_tx_byte  = byte_q;
  assign bus.o_tx_ready = ready_q;
  assign bus.o_grant_id = gid_q;
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_state    = state_q;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 Parameter GAP_CYCLES, default 2, idle clocks enforced between consecutive frames (0..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 32, max clocks from launch to i_tx_done before abort (>=16).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_req_valid  input  NUM_REQ  per-requester byte pending; held until matching o_req_ack.
REQ-007 i_req_data  input  8*NUM_REQ  byte of requester k at bits [8k+7:8k].
REQ-008 o_req_ack  output  NUM_REQ  one-hot 1-cycle pulse: requester's byte latched.
REQ-009 o_req_done  output  NUM_REQ  one-hot 1-cycle pulse: that requester's frame completed.
REQ-010 o_err  output  1  1-cycle pulse on timeout abort.
REQ-011 o_tx_byte  output  8  byte to transmitter; stable from latch until frame end.
REQ-012 o_tx_ready  output  1  1-cycle launch pulse to transmitter.
REQ-013 i_tx_done  input  1  transmitter frame-complete pulse.
REQ-014 i_tx_active  input  1  transmitter busy flag.
REQ-015 o_grant_id  output  clog2(NUM_REQ)  index of requester owning current frame.
REQ-016 o_busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT, GAP.
REQ-018 IDLE: when any i_req_valid bit is set and i_tx_active=0, select winner round-robin, latch its byte into o_tx_byte, set o_grant_id, pulse o_req_ack[winner], go to LAUNCH next cycle.
REQ-019 IDLE with i_tx_active=1 SHALL not grant; wait.
REQ-020 Round-robin: search starts at pointer P, ascending with wrap NUM_REQ-1 -> 0; after grant to k, P = (k+1) mod NUM_REQ.
REQ-021 LAUNCH: o_tx_ready=1 for exactly this cycle; clear timeout counter; go to WAIT.
REQ-022 WAIT: count cycles; on i_tx_done=1 pulse o_req_done[o_grant_id], go to GAP (or IDLE if GAP_CYCLES=0).
REQ-023 WAIT: if counter reaches TIMEOUT_CYCLES-1 without i_tx_done, pulse o_err, no o_req_done, go to GAP.
REQ-024 i_tx_done and timeout in same cycle: done wins, no o_err.
REQ-025 GAP: stay exactly GAP_CYCLES cycles, then IDLE; requests in GAP SHALL wait.
REQ-026 Grant-to-grant minimum with nominal transmitter (done 11 cycles after launch): 1+1+11+GAP_CYCLES cycles.
REQ-027 o_tx_byte and o_grant_id SHALL be held constant from latch through end of GAP.
REQ-028 i_req_valid changes for non-granted requesters during a frame SHALL not affect the current frame.
REQ-029 i_tx_done outside WAIT SHALL be ignored.
REQ-030 Single requester continuously valid SHALL be served back-to-back (pointer wrap returns to it).

Reset
REQ-031 On reset_n low, immediately: state IDLE, P=0, o_req_ack=0, o_req_done=0, o_err=0, o_tx_ready=0, o_tx_byte=8'h00, o_grant_id=0, o_busy=0, counters 0.
REQ-032 Reset mid-frame SHALL abandon frame without o_req_done or o_err; first grant after release follows P=0.

Structure
REQ-033 Shared package uart_pkg SHALL hold FSM state enum, UART_FRAME_CYCLES=11 constant, NUM_REQ default.
REQ-034 Round-robin selection SHALL be sub-module uart_rr_arbiter (inputs request vector, pointer; outputs one-hot grant, index, any).
REQ-035 Counters sized for max(TIMEOUT_CYCLES, GAP_CYCLES) without overflow.

Verification
REQ-036 Single: req1 valid byte 8'hA5 -> ack[1] next edge, tx_ready one cycle later, done[1] one cycle after tx_done, o_tx_byte=8'hA5 throughout.
REQ-037 All four valid simultaneously after reset, bytes 11,22,33,44 -> grant order 0,1,2,3, each frame separated by GAP_CYCLES=2 idle cycles.
REQ-038 Fairness: req0 and req2 always valid -> grants alternate 0,2,0,2 for 8 frames.
REQ-039 Transmitter model never returns done -> o_err pulse at launch+TIMEOUT_CYCLES, no o_req_done, next grant proceeds.
REQ-040 i_tx_active held 1 while req3 valid -> no ack until active falls; then ack[3].
REQ-041 reset_n low during WAIT -> all outputs reset values same cycle; after release req2,req0 valid -> grant 0 first.
